// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
// Serializes parallel input words MSB first and searches the resulting bit
// stream for a programmable PAT_LEN-bit pattern. A frame is a run of words
// closed by one marked in_last. Matches may overlap and may span word
// boundaries inside a frame. Matches are counted per frame.
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   cfg_we       pattern write strobe (honoured only while idle between frames)
//   cfg_pattern  new pattern, MSB is matched first
//   in_valid     input word offered
//   in_ready     input word can be accepted (high in IDLE)
//   in_data      input word, serialized MSB first
//   in_last      word is the final word of its frame
//   bit_valid    bit_out is being evaluated this cycle
//   bit_out      current serialized bit
//   match        one-cycle pulse per pattern occurrence
//   match_count  saturating count of matches in the current or last frame
//   busy         a frame is in progress
//   done         one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PAT_LEN = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               bit_valid,
    output logic               bit_out,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX    = FILL_W'(PAT_LEN);
    localparam logic [31:0]       PAT_DEFAULT = 32'b11001;

    state_t               state;
    state_t               state_next;
    logic [DATA_W-1:0]    shreg;
    logic                 last_q;
    logic [BIT_W-1:0]     bit_cnt;
    logic [PAT_LEN-1:0]   history;
    logic [FILL_W-1:0]    fill;
    logic [PAT_LEN-1:0]   pattern;
    logic                 frame_active;
    logic                 accept;
    logic [PAT_LEN-1:0]   hist_next;
    logic [FILL_W-1:0]    fill_next;
    logic                 hit;

    // State register: reset wins over everything, including a frame mid-SHIFT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state outputs. A word is taken only in IDLE, so
    // in_ready doubles as the accept qualifier. After the last bit of a word
    // we either close the frame (DONE) or go back for the next word (IDLE).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        bit_valid  = 1'b0;
        bit_out    = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = shreg[DATA_W-1];
                if (bit_cnt == BIT_LAST) begin
                    state_next = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // History after taking in the current bit (newest bit in the LSB). A hit
    // needs a full window, so the first PAT_LEN-1 bits of a frame never match.
    assign hist_next = {history[PAT_LEN-2:0], bit_out};
    assign fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign hit       = (hist_next == pattern) && (fill_next == FILL_MAX);
    assign busy      = (state != IDLE) || frame_active;

    // Datapath. History, fill and count survive between words of a frame so
    // patterns spanning a word boundary are still seen; they are cleared only
    // when the first word of a new frame is accepted. The pattern may change
    // only between frames, and a write on the same edge as the first accept
    // is already in place for the first compare of that frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg        <= '0;
            last_q       <= 1'b0;
            bit_cnt      <= '0;
            history      <= '0;
            fill         <= '0;
            pattern      <= PAT_DEFAULT[PAT_LEN-1:0];
            frame_active <= 1'b0;
            match        <= 1'b0;
            match_count  <= '0;
        end else begin
            match <= 1'b0;
            if (cfg_we && (state == IDLE) && !frame_active) begin
                pattern <= cfg_pattern;
            end
            if (accept) begin
                shreg   <= in_data;
                last_q  <= in_last;
                bit_cnt <= '0;
                if (!frame_active) begin
                    match_count  <= '0;
                    history      <= '0;
                    fill         <= '0;
                    frame_active <= 1'b1;
                end
            end
            if (state == SHIFT) begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                history <= hist_next;
                fill    <= fill_next;
                if (hit) begin
                    match <= 1'b1;
                    if (match_count != '1) begin
                        match_count <= match_count + 1'b1;
                    end
                end
            end
            if (state == DONE) begin
                frame_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
// Self-checking bench for seq_detect_ctrl. Two instances share all inputs:
// one with default parameters and one with a 2-bit match counter, so the
// saturating count is exercised alongside the normal one. Expected values
// come from a frame-level model: the bits of the current frame are kept in a
// queue and a match is declared whenever the last PAT_LEN bits equal the
// pattern, one cycle after the completing bit.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_pattern = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;

    logic       in_ready, bit_valid, bit_out, match, busy, done;
    logic [7:0] match_count;
    logic       s_in_ready, s_bit_valid, s_bit_out, s_match, s_busy, s_done;
    logic [1:0] s_match_count;

    int   nVec = 0;
    int   nErr = 0;

    bit         bitsQ[$];
    logic [4:0] patModel;
    bit         frameActive;
    bit         expMatch;
    int         cnt8;
    int         cnt2;

    seq_detect_ctrl #(.DATA_W(8), .PAT_LEN(5), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .bit_valid(bit_valid), .bit_out(bit_out), .match(match),
        .match_count(match_count), .busy(busy), .done(done)
    );

    seq_detect_ctrl #(.DATA_W(8), .PAT_LEN(5), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
        .bit_valid(s_bit_valid), .bit_out(s_bit_out), .match(s_match),
        .match_count(s_match_count), .busy(s_busy), .done(s_done)
    );

    // Free-running clock; the bench drives and samples on the falling edge.
    always #5 clock = ~clock;

    // One comparison: counted, and reported with its tag when it misses.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against the expected values.
    task automatic checkOutput(input string tag, input bit r, input bit b, input bit bv,
                               input bit bo, input bit d);
        chk({tag, ".in_ready"},    32'(in_ready),      32'(r));
        chk({tag, ".busy"},        32'(busy),          32'(b));
        chk({tag, ".bit_valid"},   32'(bit_valid),     32'(bv));
        chk({tag, ".bit_out"},     32'(bit_out),       32'(bo));
        chk({tag, ".done"},        32'(done),          32'(d));
        chk({tag, ".match"},       32'(match),         32'(expMatch));
        chk({tag, ".match_count"}, 32'(match_count),   32'(cnt8));
        chk({tag, ".s_in_ready"},  32'(s_in_ready),    32'(r));
        chk({tag, ".s_busy"},      32'(s_busy),        32'(b));
        chk({tag, ".s_bit_valid"}, 32'(s_bit_valid),   32'(bv));
        chk({tag, ".s_bit_out"},   32'(s_bit_out),     32'(bo));
        chk({tag, ".s_done"},      32'(s_done),        32'(d));
        chk({tag, ".s_match"},     32'(s_match),       32'(expMatch));
        chk({tag, ".s_count"},     32'(s_match_count), 32'(cnt2));
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                 input logic we, input logic [4:0] p);
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        cfg_we      = we;
        cfg_pattern = p;
    endtask

    task automatic modelReset();
        patModel    = 5'b11001;
        frameActive = 1'b0;
        bitsQ.delete();
        cnt8        = 0;
        cnt2        = 0;
        expMatch    = 1'b0;
    endtask

    // A new bit joins the frame; a match shows up in the following cycle.
    task automatic modelShift(input bit b);
        int n;
        bit h;
        bitsQ.push_back(b);
        n = bitsQ.size();
        h = (n >= 5);
        if (h) begin
            for (int j = 0; j < 5; j++) begin
                if (bitsQ[n-5+j] != patModel[4-j]) h = 1'b0;
            end
        end
        expMatch = h;
        if (h) begin
            cnt8 = (cnt8 == 255) ? 255 : cnt8 + 1;
            cnt2 = (cnt2 == 3) ? 3 : cnt2 + 1;
        end
    endtask

    // Idle cycles between words or frames, optionally with random pattern writes.
    task automatic idleCycles(input int n, input bit allowCfg);
        for (int i = 0; i < n; i++) begin
            logic       we;
            logic [4:0] p;
            we = allowCfg ? 1'($urandom_range(0, 1)) : 1'b0;
            p  = 5'($urandom);
            applyStimulus(1'b0, 8'($urandom), 1'($urandom), we, p);
            checkOutput("idle", 1'b1, frameActive, 1'b0, 1'b0, 1'b0);
            if (we && !frameActive) patModel = p;
            expMatch = 1'b0;
            @(negedge clock);
        end
    endtask

    // Offer one word in the current (IDLE) cycle and follow it through all of
    // its bit cycles. During SHIFT and DONE the inputs carry junk plus a pattern
    // write, all of which must be ignored. resetAt>0 pulses reset in that bit cycle.
    task automatic runWord(input logic [7:0] data, input bit last, input bit doCfg,
                           input logic [4:0] cfgPat, input int resetAt);
        applyStimulus(1'b1, data, last, doCfg, cfgPat);
        checkOutput("accept", 1'b1, frameActive, 1'b0, 1'b0, 1'b0);
        if (doCfg && !frameActive) patModel = cfgPat;
        if (!frameActive) begin
            bitsQ.delete();
            cnt8        = 0;
            cnt2        = 0;
            frameActive = 1'b1;
        end
        expMatch = 1'b0;
        @(negedge clock);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'b1, 5'($urandom));
            checkOutput("shift", 1'b0, 1'b1, 1'b1, data[8-k], 1'b0);
            if (k == resetAt) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'b00000);
                modelReset();
                checkOutput("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            modelShift(data[8-k]);
            @(negedge clock);
        end
        if (last) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'b1, 5'($urandom));
            checkOutput("done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            expMatch    = 1'b0;
            frameActive = 1'b0;
            @(negedge clock);
        end
    endtask

    // Directed scenarios first, then random frames with random pattern writes.
    initial begin
        modelReset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single word with the default pattern.
        runWord(8'b11001000, 1'b1, 1'b0, 5'b00000, 0);
        idleCycles(2, 1'b0);

        // Overlapping occurrences of a freshly written pattern.
        runWord(8'b10101010, 1'b1, 1'b1, 5'b10101, 0);
        idleCycles(1, 1'b0);

        // Pattern spanning a word boundary.
        runWord(8'b00000110, 1'b0, 1'b1, 5'b11001, 0);
        runWord(8'b01000000, 1'b1, 1'b0, 5'b00000, 0);
        idleCycles(1, 1'b0);

        // Pattern writes during SHIFT/DONE are ignored; next frame still sees 11001.
        runWord(8'b00110010, 1'b1, 1'b0, 5'b00000, 0);
        runWord(8'b11001000, 1'b1, 1'b0, 5'b00000, 0);
        idleCycles(1, 1'b0);

        // Reset in the 4th bit cycle of the second word of a frame.
        runWord(8'b11001000, 1'b0, 1'b0, 5'b00000, 0);
        runWord(8'b11111111, 1'b1, 1'b0, 5'b00000, 4);
        idleCycles(3, 1'b0);

        // Counter saturation on the 2-bit instance.
        for (int w = 0; w < 4; w++) begin
            runWord(8'b11001110, (w == 3), (w == 0), 5'b11001, 0);
        end
        idleCycles(2, 1'b0);

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                runWord(8'($urandom), (w == nw - 1), 1'($urandom_range(0, 1)), 5'($urandom), 0);
                if (w < nw - 1) idleCycles($urandom_range(0, 2), 1'b1);
            end
            idleCycles($urandom_range(0, 2), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the parallel input word width.
REQ-002 The block SHALL have parameter PAT_LEN, default 5, giving the pattern length in bits.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port cfg_we, input, 1 bit: pattern write strobe.
REQ-007 The block SHALL have port cfg_pattern, input, PAT_LEN bits: new pattern, MSB matched first.
REQ-008 The block SHALL have port in_valid, input, 1 bit: input word offered.
REQ-009 The block SHALL have port in_ready, output, 1 bit: input word can be accepted.
REQ-010 The block SHALL have port in_data, input, DATA_W bits: word, serialized MSB first.
REQ-011 The block SHALL have port in_last, input, 1 bit: word is the final word of its frame.
REQ-012 The block SHALL have port bit_valid, output, 1 bit: bit_out is being evaluated this cycle.
REQ-013 The block SHALL have port bit_out, output, 1 bit: current serialized bit.
REQ-014 The block SHALL have port match, output, 1 bit: one-cycle pulse per pattern occurrence.
REQ-015 The block SHALL have port match_count, output, CNT_W bits: matches counted in the current or last frame.
REQ-016 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.

Function
REQ-018 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-019 in_ready SHALL be 1 exactly when the state is IDLE; a word SHALL be accepted on an edge where in_valid and in_ready are both 1.
REQ-020 On accept, the block SHALL load in_data into a shift register, latch in_last, set the bit count to 0 and go to SHIFT.
REQ-021 In SHIFT, bit_valid SHALL be 1 and bit_out SHALL be the shift register MSB.
- Each edge shifts the register left, appends bit_out to the PAT_LEN-bit history (newest bit in the LSB) and increments the history fill count, saturating at PAT_LEN.
REQ-022 After DATA_W SHIFT cycles, the FSM SHALL go to DONE if the latched last flag is set, otherwise to IDLE.
- The history SHALL be retained, so patterns spanning word boundaries within a frame are detected.
REQ-023 match SHALL be a register set for exactly one cycle, on the edge where the updated history equals the pattern register and the fill count reaches PAT_LEN.
- Overlapping occurrences SHALL each be detected.
- match is high in the cycle after the completing bit.
REQ-024 match_count SHALL increment on the same edge that sets match, and SHALL saturate at all-ones.
REQ-025 On accept of the first word of a frame (frame_active=0), the block SHALL clear match_count, clear the history and fill count, and set frame_active.
REQ-026 In DONE, done SHALL be 1 for one cycle, frame_active SHALL clear, and the next state SHALL be IDLE.
- match_count SHALL hold until the next frame starts.
- A match completed by the final bit SHALL be visible in the DONE cycle, together with the updated count.
REQ-027 busy SHALL be 1 when the state is not IDLE or frame_active is 1.
REQ-028 cfg_we SHALL load cfg_pattern only when the state is IDLE and frame_active=0; otherwise it SHALL be ignored.
- If a pattern write and a first-word accept occur on the same edge, that frame SHALL use the new pattern.
REQ-029 bit_valid, bit_out, match and done SHALL be 0 when the state is not SHIFT (match and done excepted as specified above).

Reset
REQ-030 When reset is high at an edge, in any state including mid-SHIFT, the block SHALL apply the following and take priority over all other inputs:
- state IDLE; frame_active 0;
- history, fill count and bit count 0;
- match_count 0; match, done, bit_valid, bit_out 0;
- pattern register reset to 5'b11001 (zero-extended or truncated to PAT_LEN).
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-032 Single word, last: default pattern, word 8'b11001000 with in_last=1, accepted in cycle T.
- bit_valid high in T+1..T+8.
- match high only in T+6.
- done high in T+9 with match_count=1.
REQ-033 Overlap: cfg_pattern=5'b10101, then word 8'b10101010 with in_last=1.
- match high in T+6 and T+8.
- match_count=2 at done.
REQ-034 Cross-word: default pattern, words 8'b00000110 (in_last=0) then 8'b01000000 (in_last=1).
- Exactly one match, on the second bit of word 2.
- match_count=1.
REQ-035 Ignored config: cfg_we with 5'b00000 pulsed during SHIFT.
- The pattern is unchanged, and the next frame still detects 11001.
REQ-036 Reset mid-SHIFT: reset asserted in the 4th bit cycle.
- The next cycle is IDLE with in_ready=1 and busy=0.
- match_count=0.
- No match or done pulse.
REQ-037 Saturation: CNT_W=2, frame of four words 8'b11001110.
- match_count stops at 3.
- match still pulses for every occurrence.
